ssd_scan_scheduler: RTL and testbench

Time-multiplexing scheduler for the 4-digit seven-segment display, sitting between the UART receive path and `Segment_Selector`. It holds a 4-digit hex buffer loaded from received UART bytes and steps through the digits with a fixed slot period. A blanking interval between slots suppresses ghosting, and each digit shows a dash until it has been written. A startup hold keeps the display dark and ignores UART bytes for a programmable time after reset.

---
 rtl/ssd_scan_scheduler.sv | 126 ++++++++++++
 tb/tb_ssd_scan_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_scheduler.sv
// Scan scheduler for the 4-digit seven-segment display: buffers hex nibbles from
// UART bytes and time-multiplexes them with a blanking gap between digit slots.
`timescale 1ns/1ps

module ssd_scan_scheduler #(
    parameter int SCAN_DIV     = 104_167,
    parameter int BLANK_CYCLES = 500,
    parameter int STARTUP_WAIT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       clear,
    output logic       rx_ready,
    output logic [3:0] digit_nibble,
    output logic       digit_dash,
    output logic [3:0] dig_sel
);

    localparam int CNT_MAX = (STARTUP_WAIT > SCAN_DIV) ? STARTUP_WAIT : SCAN_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // The startup count is loaded from reset, so the reset interval itself is not
    // one of the counted cycles; BLANK and SHOW reload on the edge that enters them.
    localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_WAIT);
    localparam logic [CNT_W-1:0] BLANK_LOAD   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LOAD    = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);

    localparam logic [1:0] ST_STARTUP = 2'd0;
    localparam logic [1:0] ST_BLANK   = 2'd1;
    localparam logic [1:0] ST_SHOW    = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       di;
    logic [1:0]       di_next;
    logic             wp;
    logic [3:0]       written;
    logic [3:0]       digit_buf [4];
    logic             accept;
    logic             slot_done;

    assign accept    = rx_valid & rx_ready & ~clear;
    assign slot_done = (cnt == '0);
    assign di_next   = di + 2'd1;

    // NOTE: sequential state uses non-blocking assignments so every register in the
    // block samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_STARTUP;
            cnt          <= STARTUP_LOAD;
            di           <= 2'd0;
            rx_ready     <= 1'b0;
            dig_sel      <= 4'hF;
            digit_nibble <= 4'h0;
            digit_dash   <= 1'b1;
        end else begin
            case (state)
                ST_STARTUP: begin
                    if (slot_done) begin
                        state        <= ST_BLANK;
                        cnt          <= BLANK_LOAD;
                        rx_ready     <= 1'b1;
                        digit_nibble <= digit_buf[di];
                        digit_dash   <= ~written[di];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (slot_done) begin
                        state   <= ST_SHOW;
                        cnt     <= SHOW_LOAD;
                        dig_sel <= ~(4'b0001 << di);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (slot_done) begin
                        state        <= ST_BLANK;
                        cnt          <= BLANK_LOAD;
                        di           <= di_next;
                        dig_sel      <= 4'hF;
                        digit_nibble <= digit_buf[di_next];
                        digit_dash   <= ~written[di_next];
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state   <= ST_BLANK;
                    cnt     <= BLANK_LOAD;
                    dig_sel <= 4'hF;
                end
            endcase
        end
    end

    // Clear outranks a same-cycle byte because accept is gated by ~clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            written <= 4'b0000;
            wp      <= 1'b0;
        end else if (clear) begin
            written <= 4'b0000;
            wp      <= 1'b0;
        end else if (accept) begin
            written[{wp, 1'b0}] <= 1'b1;
            written[{wp, 1'b1}] <= 1'b1;
            wp                  <= ~wp;
        end
    end

    // NOTE: the digit buffer has no reset; the written flags mask stale contents,
    // so clearing the storage itself would buy nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            digit_buf[{wp, 1'b0}] <= rx_data[3:0];
            digit_buf[{wp, 1'b1}] <= rx_data[7:4];
        end
    end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Directed bench for ssd_scan_scheduler with short scan parameters and
// hand-computed slot contents.
`timescale 1ns/1ps

module tb_ssd_scan_scheduler;

    localparam int SCAN_DIV     = 20;
    localparam int BLANK_CYCLES = 4;
    localparam int STARTUP_WAIT = 10;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_valid = 1'b0;
    logic       clear    = 1'b0;
    logic       rx_ready;
    logic [3:0] digit_nibble;
    logic       digit_dash;
    logic [3:0] dig_sel;

    int total = 0;
    int bad   = 0;

    ssd_scan_scheduler #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .STARTUP_WAIT(STARTUP_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .clear       (clear),
        .rx_ready    (rx_ready),
        .digit_nibble(digit_nibble),
        .digit_dash  (digit_dash),
        .dig_sel     (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Releases reset and checks the exact startup hold and first slot timing.
    // A stray byte is offered mid-hold and must leave no trace.
    task automatic startup_check();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < STARTUP_WAIT; i++) begin
            tick();
            check("startup_hold", 32'({dig_sel, rx_ready}), 32'({4'hF, 1'b0}));
            if (i == 3) begin
                rx_data  = 8'hFF;
                rx_valid = 1'b1;
            end
            if (i == 4) rx_valid = 1'b0;
        end
        for (int i = 0; i < BLANK_CYCLES; i++) begin
            tick();
            check("first_blank", 32'({dig_sel, rx_ready}), 32'({4'hF, 1'b1}));
        end
        for (int i = 0; i < SCAN_DIV - BLANK_CYCLES; i++) begin
            tick();
            check("first_show", 32'({dig_sel, digit_dash}), 32'({4'b1110, 1'b1}));
        end
        tick();
        check("second_blank", 32'(dig_sel), 32'(4'hF));
    endtask

    // Advances to the next SHOW phase and checks which digit is lit and its content.
    task automatic next_slot(input logic [3:0] exp_sel, input logic [3:0] exp_nib,
                             input logic exp_dash);
        int n = 0;
        while (dig_sel != 4'hF && n < 50) begin
            tick();
            n++;
        end
        while (dig_sel == 4'hF && n < 100) begin
            tick();
            n++;
        end
        check("slot_bound", 32'(n >= 100), 32'(0));
        check("slot_sel", 32'(dig_sel), 32'(exp_sel));
        check("slot_dash", 32'(digit_dash), 32'(exp_dash));
        if (!exp_dash) check("slot_nibble", 32'(digit_nibble), 32'(exp_nib));
    endtask

    initial begin
        #12;
        check("reset_out", 32'({dig_sel, digit_nibble, digit_dash, rx_ready}),
              32'({4'hF, 4'h0, 1'b1, 1'b0}));
        startup_check();

        // Single byte lands on digits 0/1; scan order wraps back to digit 0.
        send(8'hA5);
        next_slot(4'b1101, 4'h0, 1'b1);
        next_slot(4'b1011, 4'h0, 1'b1);
        next_slot(4'b0111, 4'h0, 1'b1);
        next_slot(4'b1110, 4'h5, 1'b0);
        next_slot(4'b1101, 4'hA, 1'b0);

        // Pointer wrap: third byte overwrites digits 0/1, buffer becomes {5,6,3,4}.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(8'h21);
        send(8'h43);
        send(8'h65);
        next_slot(4'b1011, 4'h3, 1'b0);
        next_slot(4'b0111, 4'h4, 1'b0);
        next_slot(4'b1110, 4'h5, 1'b0);

        // Mid-slot clear colliding with a byte, then a write, while digit 0 is lit.
        clear    = 1'b1;
        rx_data  = 8'h12;
        rx_valid = 1'b1;
        tick();
        clear    = 1'b0;
        rx_valid = 1'b0;
        send(8'h0B);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_hold", 32'({digit_nibble, digit_dash, dig_sel}),
                  32'({4'h5, 1'b0, 4'b1110}));
        end
        next_slot(4'b1101, 4'h0, 1'b0);
        next_slot(4'b1011, 4'h0, 1'b1);
        next_slot(4'b0111, 4'h0, 1'b1);
        next_slot(4'b1110, 4'hB, 1'b0);
        next_slot(4'b1101, 4'h0, 1'b0);
        next_slot(4'b1011, 4'h0, 1'b1);

        // Asynchronous reset in the middle of digit 2's SHOW phase.
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check("reset_mid", 32'({dig_sel, digit_nibble, digit_dash, rx_ready}),
              32'({4'hF, 4'h0, 1'b1, 1'b0}));
        startup_check();
        next_slot(4'b1101, 4'h0, 1'b1);
        next_slot(4'b1011, 4'h0, 1'b1);
        next_slot(4'b0111, 4'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
